// File: rtl/xnor_pkg.sv
// Shared types for the convolution address sequencer: FSM state encoding and
// default-width address/dimension types.
package xnor_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DIM_W_DEF  = 16;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DIM_W_DEF-1:0]  dim_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Padding on each border of a square kernel when padding is enabled.
    function automatic int unsigned pad_amount(input int unsigned ks);
        return (ks - 32'd1) / 32'd2;
    endfunction

endpackage

// File: rtl/loop_counter.sv
// One level of a nested loop: counts 0, step, 2*step ... while <= limit, then
// wraps to 0. wrap_o flags the enabled step that wraps.
module loop_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    input  logic [W-1:0] step_i,
    output logic [W-1:0] value_o,
    output logic         wrap_o
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic [W:0]   sum_s;

    // Next value; the sum is one bit wider so the limit compare cannot alias.
    always_comb begin
        sum_s   = {1'b0, value_q} + {1'b0, step_i};
        wrap_o  = en_i && (sum_s > {1'b0, limit_i});
        value_d = value_q;
        if (clear_i) begin
            value_d = {W{1'b0}};
        end else if (en_i) begin
            value_d = wrap_o ? {W{1'b0}} : sum_s[W-1:0];
        end else begin
            value_d = value_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            value_q <= {W{1'b0}};
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/conv_address_sequencer.sv
// Convolution address sequencer: walks oc x origins x channel-words x kernel taps
// and emits input/weight/output word addresses. ADDRGEN_PADDING_EN adds zero padding.
module conv_address_sequencer
    import xnor_pkg::*;
#(
    parameter int unsigned KS        = 3,
    parameter int unsigned WORD_BITS = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DIM_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DIM_W-1:0]  iw_i,
    input  logic [DIM_W-1:0]  ih_i,
    input  logic [DIM_W-1:0]  ic_i,
    input  logic [DIM_W-1:0]  oc_i,
    input  logic [1:0]        stride_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] index_input_o,
    output logic [ADDR_W-1:0] index_weight_o,
    output logic [ADDR_W-1:0] index_output_o,
`ifdef ADDRGEN_PADDING_EN
    input  logic              pad_i,
    output logic              pad_o,
`endif
    output logic              last_o
);

    localparam int unsigned     LOG2W  = $clog2(WORD_BITS);
    localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] KS_A   = ADDR_W'(KS);
    localparam logic [ADDR_W-1:0] KS_LIM = ADDR_W'(KS - 1);

    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DIM_W-1:0]   iw_q, iw_d, ih_q, ih_d, ic_q, ic_d, oc_q, oc_d;
    logic [1:0]         stride_q, stride_d;
    logic [ADDR_W-1:0]  pix_q, pix_d;

    logic               clear_s, adv_s, final_s, degen_s, last_s, pad_tap_s;
    logic [ADDR_W-1:0]  p_in_s, p_s, step_s, icw_s, iw_a_s, ih_a_s;
    logic [ADDR_W-1:0]  oc_lim_s, icw_lim_s, ox_lim_s, oy_lim_s;
    logic [ADDR_W-1:0]  oci_v, oy_v, ox_v, ico_v, wj_v, wi_v;
    logic               oci_wrap, oy_wrap, ox_wrap, ico_wrap, wj_wrap, wi_wrap;
    logic [ADDR_W-1:0]  cx_s, cy_s, ix_s, iy_s, in_idx_s, wt_idx_s;

`ifdef ADDRGEN_PADDING_EN
    localparam logic [ADDR_W-1:0] HALF_A = ADDR_W'(pad_amount(KS));
    logic pad_q, pad_d;
    assign p_in_s = pad_i ? HALF_A : ZERO_A;
    assign p_s    = pad_q ? HALF_A : ZERO_A;
`else
    assign p_in_s = ZERO_A;
    assign p_s    = ZERO_A;
`endif

    // A job with no channel words, no output channels or no legal origin emits nothing.
    always_comb begin
        degen_s = ((ic_i >> LOG2W) == {DIM_W{1'b0}})
               || (oc_i == {DIM_W{1'b0}})
               || ((ADDR_W'(iw_i) + p_in_s + p_in_s) < KS_A)
               || ((ADDR_W'(ih_i) + p_in_s + p_in_s) < KS_A);
    end

    // Loop limits and stride derived from the latched job.
    always_comb begin
        iw_a_s    = ADDR_W'(iw_q);
        ih_a_s    = ADDR_W'(ih_q);
        step_s    = (stride_q == 2'd0) ? ONE_A : ADDR_W'(stride_q);
        icw_s     = ADDR_W'(ic_q >> LOG2W);
        oc_lim_s  = ADDR_W'(oc_q) - ONE_A;
        icw_lim_s = icw_s - ONE_A;
        ox_lim_s  = iw_a_s + p_s + p_s - KS_A;
        oy_lim_s  = ih_a_s + p_s + p_s - KS_A;
    end

    assign adv_s = valid_q && ready_i;

    loop_counter #(.W(ADDR_W)) u_wi (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_s), .en_i(adv_s),
        .limit_i(KS_LIM), .step_i(ONE_A), .value_o(wi_v), .wrap_o(wi_wrap));
    loop_counter #(.W(ADDR_W)) u_wj (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_s), .en_i(wi_wrap),
        .limit_i(KS_LIM), .step_i(ONE_A), .value_o(wj_v), .wrap_o(wj_wrap));
    loop_counter #(.W(ADDR_W)) u_ico (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_s), .en_i(wj_wrap),
        .limit_i(icw_lim_s), .step_i(ONE_A), .value_o(ico_v), .wrap_o(ico_wrap));
    loop_counter #(.W(ADDR_W)) u_ox (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_s), .en_i(ico_wrap),
        .limit_i(ox_lim_s), .step_i(step_s), .value_o(ox_v), .wrap_o(ox_wrap));
    loop_counter #(.W(ADDR_W)) u_oy (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_s), .en_i(ox_wrap),
        .limit_i(oy_lim_s), .step_i(step_s), .value_o(oy_v), .wrap_o(oy_wrap));
    loop_counter #(.W(ADDR_W)) u_oci (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_s), .en_i(oy_wrap),
        .limit_i(oc_lim_s), .step_i(ONE_A), .value_o(oci_v), .wrap_o(oci_wrap));

    assign final_s = oci_wrap;

    // Origin counters run from 0, so tap coordinates are shifted back by P.
    always_comb begin
        cx_s     = ox_v + wi_v;
        cy_s     = oy_v + wj_v;
        ix_s     = cx_s - p_s;
        iy_s     = cy_s - p_s;
`ifdef ADDRGEN_PADDING_EN
        pad_tap_s = (cx_s < p_s) || (cx_s >= (iw_a_s + p_s))
                 || (cy_s < p_s) || (cy_s >= (ih_a_s + p_s));
`else
        pad_tap_s = 1'b0;
`endif
        in_idx_s = ico_v * iw_a_s * ih_a_s + iy_s * iw_a_s + ix_s;
        wt_idx_s = ((oci_v * icw_s + ico_v) * KS_A + wj_v) * KS_A + wi_v;
        last_s   = valid_q && (ico_v == icw_lim_s) && (wj_v == KS_LIM) && (wi_v == KS_LIM);
    end

    // Job control: latch on start, count pixels, step through IDLE/RUN/DONE.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        clear_s  = 1'b0;
        pix_d    = pix_q;
        iw_d     = iw_q;
        ih_d     = ih_q;
        ic_d     = ic_q;
        oc_d     = oc_q;
        stride_d = stride_q;
`ifdef ADDRGEN_PADDING_EN
        pad_d    = pad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    iw_d     = iw_i;
                    ih_d     = ih_i;
                    ic_d     = ic_i;
                    oc_d     = oc_i;
                    stride_d = stride_i;
`ifdef ADDRGEN_PADDING_EN
                    pad_d    = pad_i;
`endif
                    clear_s  = 1'b1;
                    pix_d    = ZERO_A;
                    valid_d  = !degen_s;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!valid_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (adv_s) begin
                    if (last_s) begin
                        pix_d = pix_q + ONE_A;
                    end else begin
                        pix_d = pix_q;
                    end
                    if (final_s) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, job registers and pixel counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pix_q    <= ZERO_A;
            iw_q     <= {DIM_W{1'b0}};
            ih_q     <= {DIM_W{1'b0}};
            ic_q     <= {DIM_W{1'b0}};
            oc_q     <= {DIM_W{1'b0}};
            stride_q <= 2'd0;
`ifdef ADDRGEN_PADDING_EN
            pad_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pix_q    <= pix_d;
            iw_q     <= iw_d;
            ih_q     <= ih_d;
            ic_q     <= ic_d;
            oc_q     <= oc_d;
            stride_q <= stride_d;
`ifdef ADDRGEN_PADDING_EN
            pad_q    <= pad_d;
`endif
        end
    end

    assign valid_o        = valid_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign last_o         = last_s;
    assign index_input_o  = (valid_q && !pad_tap_s) ? in_idx_s : ZERO_A;
    assign index_weight_o = valid_q ? wt_idx_s : ZERO_A;
    assign index_output_o = valid_q ? pix_q : ZERO_A;
`ifdef ADDRGEN_PADDING_EN
    assign pad_o          = valid_q && pad_tap_s;
`endif

endmodule

// File: tb/tb_conv_address_sequencer.sv
// Table-driven bench for conv_address_sequencer (KS=3, WORD_BITS=32): each job is
// checked tuple-by-tuple against a loop model plus hand-computed count/last tuple.
module tb_conv_address_sequencer;

    typedef struct {
        int iw; int ih; int ic; int oc; int stride; int pad;
        int exp_n; int last_in; int last_wt; int last_out;
    } job_t;

    typedef struct {
        int in_idx; int wt_idx; int out_idx; bit last; bit pad;
    } tup_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [15:0] iw_i, ih_i, ic_i, oc_i;
    logic [1:0]  stride_i;
    logic        start_i, ready_i;
    logic        busy_o, done_o, valid_o, last_o;
    logic [31:0] index_input_o, index_weight_o, index_output_o;
`ifdef ADDRGEN_PADDING_EN
    logic        pad_i, pad_o;
`endif

    int   n_cmp = 0;
    int   n_fail = 0;
    tup_t exp_q[$];
    job_t jobs[8];
`ifdef ADDRGEN_PADDING_EN
    job_t pjobs[2];
`endif

    conv_address_sequencer dut (
        .clk_i(clk), .rst_ni(rst_ni), .iw_i(iw_i), .ih_i(ih_i), .ic_i(ic_i), .oc_i(oc_i),
        .stride_i(stride_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .valid_o(valid_o), .ready_i(ready_i), .index_input_o(index_input_o),
        .index_weight_o(index_weight_o), .index_output_o(index_output_o),
`ifdef ADDRGEN_PADDING_EN
        .pad_i(pad_i), .pad_o(pad_o),
`endif
        .last_o(last_o));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string nm);
        check({nm, " valid"}, {31'd0, valid_o}, 32'd0);
        check({nm, " busy"},  {31'd0, busy_o},  32'd0);
        check({nm, " done"},  {31'd0, done_o},  32'd0);
        check({nm, " last"},  {31'd0, last_o},  32'd0);
        check({nm, " in"},    index_input_o,    32'd0);
        check({nm, " wt"},    index_weight_o,   32'd0);
        check({nm, " out"},   index_output_o,   32'd0);
    endtask

    // Reference tuple stream straight from the loop nest and address formulas.
    task automatic build_model(input job_t j);
        int s, icw, pix, ix, iy;
        tup_t t;
        exp_q.delete();
        s   = (j.stride == 0) ? 1 : j.stride;
        icw = j.ic / 32;
        pix = 0;
        for (int oci = 0; oci < j.oc; oci++)
            for (int oy = -j.pad; oy <= j.ih + j.pad - 3; oy += s)
                for (int ox = -j.pad; ox <= j.iw + j.pad - 3; ox += s)
                    for (int ico = 0; ico < icw; ico++)
                        for (int wj = 0; wj < 3; wj++)
                            for (int wi = 0; wi < 3; wi++) begin
                                ix = ox + wi;
                                iy = oy + wj;
                                t.pad    = (ix < 0) || (ix >= j.iw) || (iy < 0) || (iy >= j.ih);
                                t.in_idx = t.pad ? 0 : ico * j.iw * j.ih + iy * j.iw + ix;
                                t.wt_idx = oci * 9 * icw + ico * 9 + wj * 3 + wi;
                                t.out_idx = pix;
                                t.last   = (ico == icw - 1) && (wj == 2) && (wi == 2);
                                exp_q.push_back(t);
                                if (t.last) pix++;
                            end
    endtask

    task automatic run_job(input job_t j, input int stall_at, input int abort_at, input string tag);
        int idx, cyc, stall_rem, hs_cyc;
        bit done_seen, valid_seen;
        logic [31:0] l_in, l_wt, l_out;
        build_model(j);
        l_in = 32'd0; l_wt = 32'd0; l_out = 32'd0;
        @(negedge clk);
        iw_i = 16'(j.iw); ih_i = 16'(j.ih); ic_i = 16'(j.ic); oc_i = 16'(j.oc);
        stride_i = 2'(j.stride); start_i = 1'b1; ready_i = 1'b1;
`ifdef ADDRGEN_PADDING_EN
        pad_i = (j.pad != 0);
`endif
        @(negedge clk);
        start_i = 1'b0;
        iw_i = 16'd9; ih_i = 16'd9; ic_i = 16'd96; oc_i = 16'd3; stride_i = 2'd2;
        idx = 0; cyc = 1; stall_rem = 3; hs_cyc = -1; done_seen = 1'b0; valid_seen = 1'b0;
        check({tag, " busy"}, {31'd0, busy_o}, 32'd1);
        while (!done_seen && cyc < 3000) begin
            if (abort_at >= 0 && idx == abort_at) begin
                rst_ni = 1'b0;
                @(negedge clk);
                check_idle_zero({tag, " midreset"});
                rst_ni = 1'b1;
                return;
            end
            if (done_o) begin
                done_seen = 1'b1;
            end else begin
                if (valid_o) begin
                    valid_seen = 1'b1;
                    if (idx >= exp_q.size()) begin
                        check({tag, " extra tuple"}, idx, exp_q.size());
                        idx++;
                    end else begin
                        check($sformatf("%s t%0d in", tag, idx), index_input_o, exp_q[idx].in_idx);
                        check($sformatf("%s t%0d wt", tag, idx), index_weight_o, exp_q[idx].wt_idx);
                        check($sformatf("%s t%0d out", tag, idx), index_output_o, exp_q[idx].out_idx);
                        check($sformatf("%s t%0d last", tag, idx), {31'd0, last_o}, {31'd0, exp_q[idx].last});
`ifdef ADDRGEN_PADDING_EN
                        check($sformatf("%s t%0d pad", tag, idx), {31'd0, pad_o}, {31'd0, exp_q[idx].pad});
`endif
                        if (stall_rem > 0 && idx == stall_at) begin
                            ready_i = 1'b0;
                            stall_rem--;
                        end else begin
                            ready_i = 1'b1;
                            l_in = index_input_o; l_wt = index_weight_o; l_out = index_output_o;
                            idx++;
                            if (idx == exp_q.size()) hs_cyc = cyc;
                        end
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        ready_i = 1'b1;
        check({tag, " done reached"}, {31'd0, done_seen}, 32'd1);
        check({tag, " tuple count"}, idx, j.exp_n);
        check({tag, " busy in done"}, {31'd0, busy_o}, 32'd1);
        check({tag, " valid in done"}, {31'd0, valid_o}, 32'd0);
        if (j.exp_n > 0) begin
            check({tag, " last in"}, l_in, j.last_in);
            check({tag, " last wt"}, l_wt, j.last_wt);
            check({tag, " last out"}, l_out, j.last_out);
            check({tag, " done latency"}, cyc, hs_cyc + 1);
        end else begin
            check({tag, " degenerate valid"}, {31'd0, valid_seen}, 32'd0);
            check({tag, " degenerate done cycle"}, cyc, 2);
        end
        @(negedge clk);
        check({tag, " done pulse width"}, {31'd0, done_o}, 32'd0);
        check({tag, " busy after done"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; ready_i = 1'b1;
        iw_i = 16'd0; ih_i = 16'd0; ic_i = 16'd0; oc_i = 16'd0; stride_i = 2'd0;
`ifdef ADDRGEN_PADDING_EN
        pad_i = 1'b0;
`endif
        //              iw ih  ic oc st pad  n  lin lwt lout
        jobs[0] = '{4, 4, 32, 1, 1, 0, 36,  15, 8,  3};
        jobs[1] = '{4, 4, 64, 2, 1, 0, 144, 31, 35, 7};
        jobs[2] = '{5, 5, 32, 1, 2, 0, 36,  24, 8,  3};
        jobs[3] = '{3, 3, 32, 1, 0, 0, 9,   8,  8,  0};
        jobs[4] = '{4, 4, 16, 1, 1, 0, 0,   0,  0,  0};
        jobs[5] = '{4, 4, 32, 0, 1, 0, 0,   0,  0,  0};
        jobs[6] = '{2, 4, 32, 1, 1, 0, 0,   0,  0,  0};
        jobs[7] = '{6, 4, 32, 1, 3, 0, 18,  17, 8,  1};
`ifdef ADDRGEN_PADDING_EN
        pjobs[0] = '{3, 3, 32, 1, 1, 1, 81, 0, 8, 8};
        pjobs[1] = '{3, 3, 16, 1, 1, 1, 0,  0, 0, 0};
`endif
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst_ni = 1'b1;

        for (int i = 0; i < 8; i++) run_job(jobs[i], -1, -1, $sformatf("job%0d", i));
        run_job(jobs[0], 5, -1, "stall");
        run_job(jobs[0], -1, 10, "abort");
        run_job(jobs[0], -1, -1, "restart");
`ifdef ADDRGEN_PADDING_EN
        for (int i = 0; i < 2; i++) run_job(pjobs[i], -1, -1, $sformatf("pad%0d", i));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
